gpio_share_arbiter: RTL
=======================

// Module: gpio_share_arbiter
// PURPOSE
//   Shares the 34 user GPIO pins ({mprj_io[37:5], mprj_io[0]}) between N team designs.
//   Round-robin request/grant with bounded tenure; muxes the owner's out/oeb onto the pads.
//   Inserts a turnaround window (all pins input) at every ownership change to prevent contention.
//   Sits between the team design instances and the user_project_wrapper io_out/io_oeb.
// PARAMETERS
//   N_REQ       4     number of requesters (>=1)
//   PIN_W       34    shared pin count
//   MAX_TENURE  1024  cycles an owner keeps the pins once another request is pending (>=2)
//   TURN_CYC    2     turnaround cycles with all pins released (>=1)
// PORTS
//   clk        in   1              system clock (40 MHz user clock)
//   nrst       in   1              asynchronous active-low reset
//   en         in   1              arbiter enable (LA/WB config bit)
//   req        in   N_REQ          level request per requester; held high while pins are needed
//   io_out_i   in   N_REQ*PIN_W    per-requester pin outputs, requester k at [k*PIN_W +: PIN_W]
//   io_oeb_i   in   N_REQ*PIN_W    per-requester output-enable-bar, same packing
//   grant      out  N_REQ          one-hot grant, registered
//   owner      out  clog2(N_REQ)   index of current owner; valid when busy
//   busy       out  1              pins currently owned
//   preempt    out  1              1-cycle pulse when an owner is revoked by tenure expiry
//   io_out_o   out  PIN_W          to pads
//   io_oeb_o   out  PIN_W          to pads (1 = input)
// BEHAVIOUR
//   - Reset (async, nrst=0): state IDLE, grant=0, owner=0, busy=0, preempt=0, rr_ptr=0,
//     io_out_o=0, io_oeb_o=all 1 -- takes effect immediately, including mid-grant.
//   - States: IDLE, GRANT, TURN.
//   - IDLE: if en && |req -> GRANT next cycle; winner = first set req at index >= rr_ptr,
//     wrapping to 0. Request-to-grant latency 1 cycle. grant/owner/busy registered on entry.
//   - GRANT: io_out_o = io_out_i[owner], io_oeb_o = io_oeb_i[owner] (comb from registered owner).
//     tenure counter (clog2(MAX_TENURE)+1 bits) starts at 0 on entry, +1 per cycle, saturates.
//     Exit -> TURN when any of: req[owner]==0; en==0; tenure >= MAX_TENURE-1 and
//     another req bit set (preempt=1 for that cycle, only on this cause).
//     Tenure never expires with no other requester (N_REQ=1 holds forever).
//     On exit: grant=0, busy=0, rr_ptr = (owner+1) mod N_REQ.
//   - TURN: io_out_o=0, io_oeb_o=all 1 for exactly TURN_CYC cycles, then IDLE;
//     requests during TURN are not granted until the IDLE arbitration that follows.
//   - IDLE/TURN outputs: io_out_o=0, io_oeb_o=all 1, grant=0, busy=0.
//   - Simultaneous: owner drops req while another raises -> TURN first, never direct handoff.
//     en=0 with req pending in IDLE -> stay IDLE. Requests from an ungranted requester
//     dropping before grant are simply lost (no latching).
//   - Minimum handoff gap: owner exit to next grant = TURN_CYC+1 cycles.
// STRUCTURE
//   - Package gpio_share_pkg: PIN_W default 34, state enum {IDLE, GRANT, TURN}, width helpers.
//   - Sub-module gpio_rr_picker: combinational rotating-priority pick (req, rr_ptr -> one-hot, index).
//   - Top holds FSM, tenure/turn counters, rr_ptr, output mux.
// TESTING
//   1. Reset: nrst=0 with req=4'b1111 -> grant=0, io_oeb_o=34'h3_FFFF_FFFF, io_out_o=0.
//   2. Single: en=1, req=4'b0100 -> grant=4'b0100 1 cycle later, owner=2, io_out_o=io_out_i[2];
//      drop req -> 2 cycles all-oeb, then IDLE.
//   3. Round robin: req=4'b1111 held, owners each drop after 10 cycles -> order 0,1,2,3,0,
//      gap of 3 cycles between grants.
//   4. Tenure: req0 held, req1 raised at tenure 5 -> req0 revoked at tenure 1023,
//      preempt pulse 1 cycle, grant=4'b0010 after 2 turnaround cycles.
//   5. Lone owner: only req3 high for 5000 cycles -> never preempted, preempt stays 0.
//   6. Abort: en=0 mid-grant -> TURN next cycle; nrst pulsed mid-grant -> oeb all 1 same time step.

Source files
------------

// File: rtl/gpio_share_pkg.sv
// Shared constants and width helpers for the GPIO share arbiter slice.
// The FSM state encoding is kept as localparams so older RTL can compare against it.
package gpio_share_pkg;

    localparam int unsigned GPIO_PIN_W = 34;

    // FSM state encoding: IDLE, GRANT, TURN
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_TURN  = 2'd2;

    // Index width; at least one bit so a single requester still has a port.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Counter width able to hold the value n.
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/gpio_rr_picker.sv
// Combinational rotating-priority picker: first set request at or after
// i_rr_ptr, wrapping to 0.
module gpio_rr_picker
    import gpio_share_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]        i_req,
    input  logic [idx_w(N_REQ)-1:0] i_rr_ptr,
    output logic [N_REQ-1:0]        o_grant,
    output logic [idx_w(N_REQ)-1:0] o_idx,
    output logic                    o_valid
);

    localparam int unsigned IW = idx_w(N_REQ);

    logic [IW-1:0] w_k;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_k     = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            w_k = IW'((32'(i_rr_ptr) + i) % N_REQ);
            if (!o_valid && i_req[w_k]) begin
                o_valid      = 1'b1;
                o_grant[w_k] = 1'b1;
                o_idx        = w_k;
            end
        end
    end

endmodule

// File: rtl/gpio_share_arbiter.sv
// Round-robin owner arbitration of the shared user GPIO pins with bounded tenure
// and an all-input turnaround window on every ownership change.
module gpio_share_arbiter
    import gpio_share_pkg::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned PIN_W      = GPIO_PIN_W,
    parameter int unsigned MAX_TENURE = 1024,
    parameter int unsigned TURN_CYC   = 2
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     en,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*PIN_W-1:0]   io_out_i,
    input  logic [N_REQ*PIN_W-1:0]   io_oeb_i,
    output logic [N_REQ-1:0]         grant,
    output logic [idx_w(N_REQ)-1:0]  owner,
    output logic                     busy,
    output logic                     preempt,
    output logic [PIN_W-1:0]         io_out_o,
    output logic [PIN_W-1:0]         io_oeb_o
);

    localparam int unsigned IW = idx_w(N_REQ);
    localparam int unsigned TW = cnt_w(MAX_TENURE);
    localparam int unsigned CW = cnt_w(TURN_CYC);

    logic [1:0]       r_state;
    logic [N_REQ-1:0] r_grant;
    logic [IW-1:0]    r_owner;
    logic [IW-1:0]    r_rr_ptr;
    logic             r_busy;
    logic             r_preempt;
    logic [TW-1:0]    r_tenure;
    logic [CW-1:0]    r_turn;

    logic [N_REQ-1:0] w_pick_oh;
    logic [IW-1:0]    w_pick_idx;
    logic             w_pick_vld;
    logic             w_own_req;
    logic             w_others;
    logic             w_expire;
    logic             w_exit;
    logic [IW-1:0]    w_next_ptr;
    logic [PIN_W-1:0] w_out_sel;
    logic [PIN_W-1:0] w_oeb_sel;

    gpio_rr_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .i_req    (req),
        .i_rr_ptr (r_rr_ptr),
        .o_grant  (w_pick_oh),
        .o_idx    (w_pick_idx),
        .o_valid  (w_pick_vld)
    );

    // r_grant is one-hot of the owner while busy, so it doubles as the owner mask.
    assign w_own_req  = |(req & r_grant);
    assign w_others   = |(req & ~r_grant);
    assign w_expire   = (r_tenure >= TW'(MAX_TENURE - 1)) && w_others;
    assign w_exit     = !w_own_req || !en || w_expire;
    assign w_next_ptr = (r_owner == IW'(N_REQ - 1)) ? '0 : r_owner + 1'b1;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_owner   <= '0;
            r_rr_ptr  <= '0;
            r_busy    <= 1'b0;
            r_preempt <= 1'b0;
            r_tenure  <= '0;
            r_turn    <= '0;
        end else begin
            r_preempt <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (en && w_pick_vld) begin
                        r_state  <= ST_GRANT;
                        r_grant  <= w_pick_oh;
                        r_owner  <= w_pick_idx;
                        r_busy   <= 1'b1;
                        r_tenure <= '0;
                    end
                end
                ST_GRANT: begin
                    if (w_exit) begin
                        r_state   <= ST_TURN;
                        r_grant   <= '0;
                        r_busy    <= 1'b0;
                        r_turn    <= '0;
                        r_rr_ptr  <= w_next_ptr;
                        // Pulse only when tenure expiry alone forced the exit.
                        r_preempt <= w_expire && w_own_req && en;
                    end else if (r_tenure != '1) begin
                        r_tenure <= r_tenure + 1'b1;
                    end
                end
                ST_TURN: begin
                    if (r_turn == CW'(TURN_CYC - 1)) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_turn <= r_turn + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_out_sel = '0;
        w_oeb_sel = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (r_grant[k]) begin
                w_out_sel = w_out_sel | io_out_i[k*PIN_W +: PIN_W];
                w_oeb_sel = w_oeb_sel | io_oeb_i[k*PIN_W +: PIN_W];
            end
        end
    end

    assign io_out_o = w_out_sel;
    assign io_oeb_o = r_busy ? w_oeb_sel : '1;
    assign grant    = r_grant;
    assign owner    = r_owner;
    assign busy     = r_busy;
    assign preempt  = r_preempt;

endmodule
